// File: rtl/core_pkg.sv
// Shared lane/VRF geometry and the load-collector buffer types.
package core_pkg;

  localparam int unsigned NrLane       = 4;
  localparam int unsigned LogNrLane    = (NrLane > 1) ? $clog2(NrLane) : 1;
  localparam int unsigned VrfAddrWidth = 8;
  localparam int unsigned DataWidth    = 64;
  localparam int unsigned StrbWidth    = DataWidth / 8;

  typedef logic [DataWidth-1:0]    vrf_data_t;
  typedef logic [StrbWidth-1:0]    vrf_strb_t;
  typedef logic [VrfAddrWidth-1:0] vrf_addr_t;

  typedef vrf_data_t [NrLane-1:0] lane_data_arr_t;
  typedef vrf_strb_t [NrLane-1:0] lane_strb_arr_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } collect_buf_state_e;

endpackage

// File: rtl/lane_collect_buffer.sv
// One lane-wide accumulation buffer: masked byte merge while filling,
// per-lane pending tracking while draining.
module lane_collect_buffer import core_pkg::*; #(
  parameter int unsigned NrLane       = core_pkg::NrLane,
  parameter int unsigned VrfAddrWidth = core_pkg::VrfAddrWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_en_i,
  input  logic                         complete_i,
  input  vrf_data_t [NrLane-1:0]       data_i,
  input  vrf_strb_t [NrLane-1:0]       mask_i,
  input  logic [VrfAddrWidth-1:0]      addr_i,
  input  logic [NrLane-1:0]            ack_i,
  output collect_buf_state_e           state_o,
  output collect_buf_state_e           state_nxt_c,
  output vrf_data_t [NrLane-1:0]       data_o,
  output vrf_strb_t [NrLane-1:0]       strb_o,
  output logic [NrLane-1:0]            pending_o,
  output logic [VrfAddrWidth-1:0]      addr_o
);

  collect_buf_state_e          state_q, state_d;
  vrf_data_t [NrLane-1:0]      data_q, data_d;
  vrf_strb_t [NrLane-1:0]      strb_q, strb_d;
  logic [NrLane-1:0]           pending_q, pending_d;
  logic [VrfAddrWidth-1:0]     addr_q, addr_d;

  vrf_data_t [NrLane-1:0]      merged_data;
  vrf_strb_t [NrLane-1:0]      merged_strb;
  logic [NrLane-1:0]           has_strb;

  // Byte-granular merge of the incoming beat into the held word
  assign merged_strb = strb_q | mask_i;

  for (genvar l = 0; l < NrLane; l++) begin : g_lane
    assign has_strb[l] = |merged_strb[l];
    for (genvar b = 0; b < StrbWidth; b++) begin : g_byte
      assign merged_data[l][8*b +: 8] = mask_i[l][b] ? data_i[l][8*b +: 8]
                                                     : data_q[l][8*b +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    strb_d    = strb_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    case (state_q)
      EMPTY, FILL: begin
        if (wr_en_i) begin
          data_d  = merged_data;
          strb_d  = merged_strb;
          state_d = FILL;
          if (complete_i) begin
            addr_d    = addr_i;
            pending_d = has_strb;
            // A word with no written bytes has nothing to drain
            if (|has_strb) begin
              state_d = DRAIN;
            end else begin
              state_d = EMPTY;
              strb_d  = '0;
            end
          end
        end
      end
      DRAIN: begin
        pending_d = pending_q & ~ack_i;
        if (pending_d == '0) begin
          state_d = EMPTY;
          strb_d  = '0;
        end
      end
      default: begin
        state_d   = EMPTY;
        strb_d    = '0;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= EMPTY;
      data_q    <= '0;
      strb_q    <= '0;
      pending_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
    end
  end

  assign state_o     = state_q;
  assign state_nxt_c = state_d;
  assign data_o      = data_q;
  assign strb_o      = strb_q;
  assign pending_o   = pending_q;
  assign addr_o      = addr_q;

endmodule

// File: rtl/load_lane_collector.sv
// Collects shuffled load beats into ping-pong lane-wide buffers and drains
// completed words as independent per-lane VRF write requests.
module load_lane_collector import core_pkg::*; #(
  parameter  int unsigned NrLane       = core_pkg::NrLane,
  parameter  int unsigned VrfAddrWidth = core_pkg::VrfAddrWidth,
  localparam int unsigned LogNrLane    = (NrLane > 1) ? $clog2(NrLane) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [VrfAddrWidth-1:0]  vaddr_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  vrf_data_t [NrLane-1:0]   data_i,
  input  vrf_strb_t [NrLane-1:0]   mask_i,
  input  logic [LogNrLane-1:0]     sel_i,
  input  logic                     last_i,
  output logic [NrLane-1:0]        lane_valid_o,
  input  logic [NrLane-1:0]        lane_ready_i,
  output logic [VrfAddrWidth-1:0]  lane_addr_o,
  output vrf_data_t [NrLane-1:0]   lane_data_o,
  output vrf_strb_t [NrLane-1:0]   lane_strb_o,
  output logic                     busy_o,
  output logic                     done_o
);

  logic                    busy_q, last_seen_q, done_q;
  logic                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [VrfAddrWidth-1:0] addr_q;
  logic [LogNrLane-1:0]    last_sel_q;

  collect_buf_state_e      buf_state     [2];
  collect_buf_state_e      buf_state_nxt [2];
  vrf_data_t [NrLane-1:0]  buf_data      [2];
  vrf_strb_t [NrLane-1:0]  buf_strb      [2];
  logic [NrLane-1:0]       buf_pending   [2];
  logic [VrfAddrWidth-1:0] buf_addr      [2];

  logic start_acc, accept, word_end, complete, done_event;

  assign start_acc = start_i & ~busy_q;
  assign ready_o   = busy_q & ~last_seen_q & (buf_state[wr_ptr_q] != DRAIN);
  assign accept    = valid_i & ready_o;
  assign word_end  = (sel_i == LogNrLane'(NrLane - 1)) | last_i;
  assign complete  = accept & word_end;

  for (genvar b = 0; b < 2; b++) begin : g_buf
    lane_collect_buffer #(
      .NrLane       (NrLane),
      .VrfAddrWidth (VrfAddrWidth)
    ) i_buf (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .wr_en_i     (accept & (wr_ptr_q == 1'(b))),
      .complete_i  (word_end),
      .data_i      (data_i),
      .mask_i      (mask_i),
      .addr_i      (addr_q),
      .ack_i       (lane_ready_i & {NrLane{rd_ptr_q == 1'(b)}}),
      .state_o     (buf_state[b]),
      .state_nxt_c (buf_state_nxt[b]),
      .data_o      (buf_data[b]),
      .strb_o      (buf_strb[b]),
      .pending_o   (buf_pending[b]),
      .addr_o      (buf_addr[b])
    );
  end

  // rd_ptr tracks the oldest undrained word; with nothing to drain it waits
  // on the buffer that will complete next, which skips zero-strobe words.
  always_comb begin
    wr_ptr_d = complete ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (buf_state_nxt[rd_ptr_q] != DRAIN) begin
      if (buf_state_nxt[~rd_ptr_q] == DRAIN) rd_ptr_d = ~rd_ptr_q;
      else                                   rd_ptr_d = wr_ptr_d;
    end
  end

  assign done_event = busy_q & (last_seen_q | (complete & last_i))
                    & (buf_state_nxt[0] != DRAIN) & (buf_state_nxt[1] != DRAIN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= 1'b0;
      last_seen_q <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      addr_q      <= '0;
      last_sel_q  <= '0;
    end else begin
      if (start_acc) begin
        busy_q      <= 1'b1;
        last_seen_q <= 1'b0;
        addr_q      <= vaddr_i;
      end else begin
        if (done_event) busy_q <= 1'b0;
        if (complete) begin
          addr_q <= addr_q + VrfAddrWidth'(1);
          if (last_i) last_seen_q <= 1'b1;
        end
      end
      done_q   <= done_event;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (accept) last_sel_q <= sel_i;
    end
  end

  assign lane_valid_o = (buf_state[rd_ptr_q] == DRAIN) ? buf_pending[rd_ptr_q] : '0;
  assign lane_addr_o  = buf_addr[rd_ptr_q];
  assign lane_data_o  = buf_data[rd_ptr_q];
  assign lane_strb_o  = buf_strb[rd_ptr_q];
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  // Slot index may not step backwards inside a word
  sel_monotonic_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (accept && (buf_state[wr_ptr_q] == FILL)) |-> (sel_i >= last_sel_q));

endmodule

// File: doc/load_lane_collector.md
Name: load_lane_collector

Overview:
- Sits directly downstream of the memory-load shuffler.
- Per VRF-word beat, takes the shuffler's per-lane data and byte strobes and merges them under mask into a lane-wide accumulation buffer.
- On word completion (last sel, or end of instruction), issues independent per-lane VRF write requests with valid/ready handshakes.
- Two ping-pong buffers, so accumulation overlaps lane draining.

Parameters:
- NrLane, core_pkg::NrLane, number of lanes (1,2,4,8,16).
- VrfAddrWidth, core_pkg::VrfAddrWidth, width of the per-lane VRF word address.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  begin new load instruction; accepted only when busy_o=0
- vaddr_i  input  VrfAddrWidth  first VRF word address of destination, sampled on accepted start_i
- valid_i  input  1  shuffled beat valid
- ready_o  output  1  beat accepted when valid_i & ready_o
- data_i  input  NrLane x vrf_data_t  shuffled per-lane data
- mask_i  input  NrLane x vrf_strb_t  shuffled per-lane byte strobes
- sel_i  input  LogNrLane  slot index of the beat (same sel as fed to shuffler)
- last_i  input  1  final beat of the instruction
- lane_valid_o  output  NrLane  per-lane write request
- lane_ready_i  input  NrLane  per-lane write accept
- lane_addr_o  output  VrfAddrWidth  word address, common to all lanes
- lane_data_o  output  NrLane x vrf_data_t  write data
- lane_strb_o  output  NrLane x vrf_strb_t  byte write enables
- busy_o  output  1  instruction in progress or buffers not drained
- done_o  output  1  one-cycle pulse when final word fully drained

Behaviour:
- Reset: both buffers EMPTY, strobes cleared, wr_ptr=rd_ptr=0, addr counter 0, busy_o=0, done_o=0, lane_valid_o=0, ready_o=0.
- Buffer states: EMPTY -> FILL (first accepted beat) -> DRAIN (word completed) -> EMPTY (all pending lanes accepted).
- ready_o = busy_o & (buf[wr_ptr] is EMPTY or FILL). Registered state only; no combinational path from lane_ready_i or valid_i.
- Accepted beat: for every byte with mask_i=1, write data_i into buf[wr_ptr] and OR the strobe in. Unmasked bytes are unchanged.
- Word completion:
  - Triggered when sel_i==NrLane-1 or last_i is set on an accepted beat.
  - buf[wr_ptr] -> DRAIN, tagged with the current addr.
  - addr increments by 1, wrapping modulo 2^VrfAddrWidth.
  - wr_ptr toggles.
  - pending[l] = |strb[l]. Lanes with all-zero strobes never raise valid.
  - If all pending bits are 0: the buffer goes straight to EMPTY and is counted as drained.
- Latency: completing beat at cycle t -> lane_valid_o visible at t+1.
- Drain:
  - Only buf[rd_ptr] in DRAIN is presented.
  - lane_valid_o[l] = pending[l]; pending[l] clears on lane_valid_o[l] & lane_ready_i[l].
  - Lanes complete in any order.
  - Once pending==0, the buffer goes EMPTY (strobes cleared) and rd_ptr toggles next cycle.
  - Valid stays high and data/addr stay stable until accepted.
- Simultaneous fill completion and drain completion of different buffers in one cycle: both take effect.
- A buffer freed at cycle t accepts beats from t+1.
- last_i: after completion, ready_o=0 until the next start_i.
  - done_o pulses the cycle the last-tagged buffer empties; busy_o drops in the same cycle.
- start_i while busy_o=1: ignored. valid_i while busy_o=0: not accepted.
- sel_i must be non-decreasing within a word; violation is flagged by an assertion, no recovery.
- Reset mid-operation: all state discarded immediately, outputs return to reset values.

Decomposition:
- core_pkg: vrf_addr_t (VrfAddrWidth), lane_strb_arr_t, lane_data_arr_t (NrLane-packed), collect_buf_state_e {EMPTY, FILL, DRAIN}.
- One natural sub-module: lane_collect_buffer (single buffer entry with state, merge, pending tracking), instantiated twice.

Test Plan:
- NrLane=4, vaddr_i=0x10, four full-strobe beats sel 0..3, lane_ready_i=4'hF, last_i on sel 3 -> lane_valid_o=4'hF one cycle after the sel-3 beat with lane_addr_o=0x10; done_o pulses on the drain cycle.
- Partial first/last: single beat sel=0, last_i=1, mask_i has lane 0 = 8'hF0 and lanes 1-3 zero -> only lane_valid_o[0] raised, lane_strb_o[0]=8'hF0; done_o after lane 0 accepted.
- Back-pressure: two full words, lane_ready_i=0 for 10 cycles -> second word fills; ready_o drops when both buffers are DRAIN; no data lost; addresses 0x10 then 0x11 drain in order.
- Out-of-order lane accept: lane_ready_i asserted lanes 3,1,0,2 on successive cycles -> each valid drops individually; rd_ptr advances only after lane 2.
- All-zero-strobe word: sel 0..3 with mask_i=0 -> no lane_valid_o; addr still increments; next word drains at vaddr+1.
- Reset asserted mid-drain with lane_valid_o=4'hF -> all outputs 0 asynchronously; after release, start_i accepted; new word addressed from new vaddr_i.
